// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: shared constants for the PC / fetch front end.
//   PCSEL_* : redirect codes produced by the branch/jump select logic
//   RESET_PC_DEF : default first fetch address (BIOS base)
//   fetch_state_e : fetch FSM encodings
package pc_fetch_unit_pkg;
  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h4000_0000;

  localparam logic [1:0] PCSEL_PC4 = 2'b00;
  localparam logic [1:0] PCSEL_JAL = 2'b01;
  localparam logic [1:0] PCSEL_BR  = 2'b10;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_if: redirect inputs and fetch/IF-ID outputs of the fetch unit.
//   master : the fetch unit (drives imem_addr/imem_en/pc_if/pc_id/valid_id/kill_id)
//   slave  : the core / memory side (drives pc_sel, targets, stall)
interface pc_fetch_if #(parameter int XLEN = 32);
  logic [1:0]      pc_sel;
  logic [XLEN-1:0] jal_target;
  logic [XLEN-1:0] br_jalr_target;
  logic            stall;
  logic [XLEN-1:0] imem_addr;
  logic            imem_en;
  logic [XLEN-1:0] pc_if;
  logic [XLEN-1:0] pc_id;
  logic            valid_id;
  logic            kill_id;

  modport master (
    input  pc_sel, jal_target, br_jalr_target, stall,
    output imem_addr, imem_en, pc_if, pc_id, valid_id, kill_id
  );
  modport slave (
    output pc_sel, jal_target, br_jalr_target, stall,
    input  imem_addr, imem_en, pc_if, pc_id, valid_id, kill_id
  );
endinterface

// File: rtl/pc_fetch_unit_next_mux.sv
// pc_next_mux: combinational next fetch address.
//   pc_sel, jal_target, br_jalr_target, stall, pc_if in; next_pc out.
//   Any redirect beats stall; PC+4 wraps modulo 2^XLEN.
module pc_next_mux import pc_fetch_unit_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] pc_if,
  input  logic [XLEN-1:0] jal_target,
  input  logic [XLEN-1:0] br_jalr_target,
  input  logic            stall,
  output logic [XLEN-1:0] next_pc
);
  localparam logic [XLEN-1:0] FOUR = {{(XLEN-3){1'b0}}, 3'b100};

  always_comb begin
    next_pc = pc_if + FOUR;
    // Bit 1 alone selects EX target, so the illegal 11 code acts as 10.
    if (pc_sel[1])                next_pc = {br_jalr_target[XLEN-1:1], 1'b0};
    else if (pc_sel == PCSEL_JAL) next_pc = jal_target;
    else if (stall)               next_pc = pc_if;
  end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter, fetch request and IF->ID register.
//   clk, rst_n (async, active low)
//   fif (pc_fetch_if.master): pc_sel/targets/stall in; imem_addr, imem_en,
//     pc_if, pc_id, valid_id, kill_id out
//   redirect_cnt: only when PC_REDIRECT_CNT_EN is defined; saturating count
//     of RUN edges with a redirect.
module pc_fetch_unit import pc_fetch_unit_pkg::*; #(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic     clk,
  input  logic     rst_n,
  pc_fetch_if.master fif
`ifdef PC_REDIRECT_CNT_EN
  ,
  output logic [31:0] redirect_cnt
`endif
);
  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc_if_q, pc_id_q, next_pc;
  logic            valid_id_q;
  logic            redirect;

  assign redirect = (fif.pc_sel != PCSEL_PC4);

  pc_next_mux #(.XLEN(XLEN)) u_mux (
    .pc_sel         (fif.pc_sel),
    .pc_if          (pc_if_q),
    .jal_target     (fif.jal_target),
    .br_jalr_target (fif.br_jalr_target),
    .stall          (fif.stall),
    .next_pc        (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    fif.imem_addr = RESET_PC;
    fif.kill_id   = 1'b0;
    case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        fif.imem_addr = next_pc;
        // EX redirect: the ID word is wrong-path too, bubble it now.
        fif.kill_id   = fif.pc_sel[1];
      end
      default: state_nxt = BOOT;
    endcase
  end

  // Fetch is on in both states; only reset itself silences memory.
  assign fif.imem_en = rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_if_q    <= RESET_PC;
      pc_id_q    <= '0;
      valid_id_q <= 1'b0;
    end else if (state == BOOT) begin
      pc_if_q    <= RESET_PC;
      valid_id_q <= 1'b0;
    end else begin
      pc_if_q <= next_pc;
      if (redirect) begin
        // Word arriving for pc_if is wrong-path: move it in as a dead slot.
        pc_id_q    <= pc_if_q;
        valid_id_q <= 1'b0;
      end else if (!fif.stall) begin
        pc_id_q    <= pc_if_q;
        valid_id_q <= 1'b1;
      end
    end
  end

  assign fif.pc_if    = pc_if_q;
  assign fif.pc_id    = pc_id_q;
  assign fif.valid_id = valid_id_q;

`ifdef PC_REDIRECT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      redirect_cnt <= '0;
    else if (state == RUN && redirect && redirect_cnt != 32'hFFFF_FFFF)
      redirect_cnt <= redirect_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed vectors for pc_fetch_unit. The driver applies one
// vector per cycle (just after the rising edge) and queues the hand-computed
// outputs; a monitor on the falling edge pops and compares. Checks redirect_cnt
// too when PC_REDIRECT_CNT_EN is defined.
module tb_pc_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  pc_fetch_if #(.XLEN(32)) fif ();

`ifdef PC_REDIRECT_CNT_EN
  logic [31:0] redirect_cnt;
`endif

  pc_fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fif   (fif)
`ifdef PC_REDIRECT_CNT_EN
    ,
    .redirect_cnt (redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] addr;
    logic        en;
    logic [31:0] pcif;
    logic [31:0] pcid;
    logic        vld;
    logic        kill;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL vec%0d %s got=%h want=%h", id, name, act, req);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("imem_addr", e.id, fif.imem_addr, e.addr);
      chk("imem_en",   e.id, {31'd0, fif.imem_en},  {31'd0, e.en});
      chk("pc_if",     e.id, fif.pc_if, e.pcif);
      chk("pc_id",     e.id, fif.pc_id, e.pcid);
      chk("valid_id",  e.id, {31'd0, fif.valid_id}, {31'd0, e.vld});
      chk("kill_id",   e.id, {31'd0, fif.kill_id},  {31'd0, e.kill});
`ifdef PC_REDIRECT_CNT_EN
      chk("redirect_cnt", e.id, redirect_cnt, e.cnt);
`endif
    end
  end

  int vec_id = 0;

  task automatic step(input logic rst, input logic [1:0] sel, input logic [31:0] jal,
                      input logic [31:0] br, input logic stl,
                      input logic [31:0] a, input logic en, input logic [31:0] pif,
                      input logic [31:0] pid, input logic v, input logic k,
                      input logic [31:0] c);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n              = rst;
    fif.pc_sel         = sel;
    fif.jal_target     = jal;
    fif.br_jalr_target = br;
    fif.stall          = stl;
    e.id = vec_id; e.addr = a; e.en = en; e.pcif = pif; e.pcid = pid;
    e.vld = v; e.kill = k; e.cnt = c;
    exp_q.push_back(e);
    vec_id++;
  endtask

  initial begin
    fif.pc_sel = 2'b00; fif.jal_target = '0; fif.br_jalr_target = '0; fif.stall = 1'b0;
    //    rst sel    jal           br            stl  imem_addr     en pc_if         pc_id         v  k  cnt
    step(0, 2'b00, 32'h0,        32'h0,        0, 32'h4000_0000, 0, 32'h4000_0000, 32'h0,        0, 0, 0); // in reset
    step(1, 2'b10, 32'h0,        32'h0000_0777, 1, 32'h4000_0000, 1, 32'h4000_0000, 32'h0,        0, 0, 0); // BOOT ignores sel/stall
    step(1, 2'b00, 32'h0,        32'h0,        0, 32'h4000_0004, 1, 32'h4000_0000, 32'h0,        0, 0, 0);
    step(1, 2'b00, 32'h0,        32'h0,        0, 32'h4000_0008, 1, 32'h4000_0004, 32'h4000_0000, 1, 0, 0);
    step(1, 2'b10, 32'h0,        32'h0000_1235, 0, 32'h0000_1234, 1, 32'h4000_0008, 32'h4000_0004, 1, 1, 0); // branch
    step(1, 2'b00, 32'h0,        32'h0,        0, 32'h0000_1238, 1, 32'h0000_1234, 32'h4000_0008, 0, 0, 1);
    step(1, 2'b01, 32'h4000_0100, 32'h0,       0, 32'h4000_0100, 1, 32'h0000_1238, 32'h0000_1234, 1, 0, 1); // JAL
    step(1, 2'b00, 32'h0,        32'h0,        0, 32'h4000_0104, 1, 32'h4000_0100, 32'h0000_1238, 0, 0, 2);
    step(1, 2'b00, 32'h0,        32'h0,        1, 32'h4000_0104, 1, 32'h4000_0104, 32'h4000_0100, 1, 0, 2); // stall x3
    step(1, 2'b00, 32'h0,        32'h0,        1, 32'h4000_0104, 1, 32'h4000_0104, 32'h4000_0100, 1, 0, 2);
    step(1, 2'b00, 32'h0,        32'h0,        1, 32'h4000_0104, 1, 32'h4000_0104, 32'h4000_0100, 1, 0, 2);
    step(1, 2'b10, 32'h0,        32'h0000_2000, 1, 32'h0000_2000, 1, 32'h4000_0104, 32'h4000_0100, 1, 1, 2); // stall+redirect
    step(1, 2'b11, 32'h0,        32'h0000_3001, 0, 32'h0000_3000, 1, 32'h0000_2000, 32'h4000_0104, 0, 1, 3); // 11 acts as 10
    step(1, 2'b01, 32'hFFFF_FFFC, 32'h0,       0, 32'hFFFF_FFFC, 1, 32'h0000_3000, 32'h0000_2000, 0, 0, 4);
    step(1, 2'b00, 32'h0,        32'h0,        0, 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'h0000_3000, 0, 0, 5); // wrap
    step(1, 2'b00, 32'h0,        32'h0,        0, 32'h0000_0004, 1, 32'h0000_0000, 32'hFFFF_FFFC, 1, 0, 5);
    step(1, 2'b10, 32'h0,        32'h0000_5000, 0, 32'h0000_5000, 1, 32'h0000_0004, 32'h0000_0000, 1, 1, 5);
    step(0, 2'b00, 32'h0,        32'h0,        0, 32'h4000_0000, 0, 32'h4000_0000, 32'h0,        0, 0, 0); // mid-run reset
    step(1, 2'b00, 32'h0,        32'h0,        0, 32'h4000_0000, 1, 32'h4000_0000, 32'h0,        0, 0, 0); // BOOT again
    step(1, 2'b00, 32'h0,        32'h0,        0, 32'h4000_0004, 1, 32'h4000_0000, 32'h0,        0, 0, 0);
    step(1, 2'b00, 32'h0,        32'h0,        0, 32'h4000_0008, 1, 32'h4000_0004, 32'h4000_0000, 1, 0, 0);

    for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
